// File: rtl/cpu_pkg.sv
// Shared core types: datapath widths and the decoder control bundle.
// CTRL_BUBBLE is the all-zero control word that a bubble carries down the pipe.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic       MemRead;
    logic       ALUSrc;
    logic       Jump;
    logic       SAJ;
    logic       Jump_Register;
    logic       Branch_equal;
    logic       Branch_not_equal;
    logic       Branch_greater;
    logic       Branch_less;
    logic [1:0] MemWrite;
    logic [1:0] MemToReg;
    logic [2:0] RegWrite;
    logic [3:0] ALUOp1;
    logic [3:0] ALUOp2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector between the load in EX and the instruction in ID.
// Latency: combinational. Backpressure: stall_if_id holds IF/ID; suppressed when EX flushes.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              flush_ex,
  output logic              load_use,
  output logic              stall_if_id
);

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_valid & ex_MemRead & (ex_rd != '0) & valid_id &
                    ((ex_rd == rs1_id) | (ex_rd == rs2_id));

  // A flushed ID instruction is dead; holding it would only waste a cycle.
  assign stall_if_id = load_use & ~flush_ex;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder controls and operands, bubbles on flush/load-use/invalid.
// Latency: 1 cycle. Backpressure: stall_if_id (comb) on load-use; optional ID_EX_BUBBLE_CNT_EN counter.
module id_ex_stage #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic              MemRead,
  input  logic              ALUSrc,
  input  logic              Jump,
  input  logic              SAJ,
  input  logic              Jump_Register,
  input  logic              Branch_equal,
  input  logic              Branch_not_equal,
  input  logic              Branch_greater,
  input  logic              Branch_less,
  input  logic [1:0]        MemWrite,
  input  logic [1:0]        MemToReg,
  input  logic [2:0]        RegWrite,
  input  logic [3:0]        ALUOp1,
  input  logic [3:0]        ALUOp2,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              flush_ex,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic              ex_MemRead,
  output logic              ex_ALUSrc,
  output logic              ex_Jump,
  output logic              ex_SAJ,
  output logic              ex_Jump_Register,
  output logic              ex_Branch_equal,
  output logic              ex_Branch_not_equal,
  output logic              ex_Branch_greater,
  output logic              ex_Branch_less,
  output logic [1:0]        ex_MemWrite,
  output logic [1:0]        ex_MemToReg,
  output logic [2:0]        ex_RegWrite,
  output logic [3:0]        ex_ALUOp1,
  output logic [3:0]        ex_ALUOp2,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  import cpu_pkg::*;

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              load_use;

  assign ctrl_in = '{MemRead: MemRead, ALUSrc: ALUSrc, Jump: Jump, SAJ: SAJ,
                     Jump_Register: Jump_Register, Branch_equal: Branch_equal,
                     Branch_not_equal: Branch_not_equal, Branch_greater: Branch_greater,
                     Branch_less: Branch_less, MemWrite: MemWrite, MemToReg: MemToReg,
                     RegWrite: RegWrite, ALUOp1: ALUOp1, ALUOp2: ALUOp2};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_MemRead  (ctrl_q.MemRead),
    .ex_rd       (rd_q),
    .valid_id    (valid_id),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .flush_ex    (flush_ex),
    .load_use    (load_use),
    .stall_if_id (stall_if_id)
  );

  // Flush, load-use and an empty ID slot all collapse to the same zeroed bubble.
  always_comb begin
    ctrl_d     = CTRL_BUBBLE;
    valid_d    = 1'b0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    if (!flush_ex && !load_use && valid_id) begin
      ctrl_d     = ctrl_in;
      valid_d    = 1'b1;
      pc_d       = pc_id;
      rs1_data_d = rs1_data_id;
      rs2_data_d = rs2_data_id;
      imm_d      = imm_id;
      rs1_d      = rs1_id;
      rs2_d      = rs2_id;
      rd_d       = rd_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= CTRL_BUBBLE;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid            = valid_q;
  assign ex_MemRead          = ctrl_q.MemRead;
  assign ex_ALUSrc           = ctrl_q.ALUSrc;
  assign ex_Jump             = ctrl_q.Jump;
  assign ex_SAJ              = ctrl_q.SAJ;
  assign ex_Jump_Register    = ctrl_q.Jump_Register;
  assign ex_Branch_equal     = ctrl_q.Branch_equal;
  assign ex_Branch_not_equal = ctrl_q.Branch_not_equal;
  assign ex_Branch_greater   = ctrl_q.Branch_greater;
  assign ex_Branch_less      = ctrl_q.Branch_less;
  assign ex_MemWrite         = ctrl_q.MemWrite;
  assign ex_MemToReg         = ctrl_q.MemToReg;
  assign ex_RegWrite         = ctrl_q.RegWrite;
  assign ex_ALUOp1           = ctrl_q.ALUOp1;
  assign ex_ALUOp2           = ctrl_q.ALUOp2;
  assign ex_pc               = pc_q;
  assign ex_rs1_data         = rs1_data_q;
  assign ex_rs2_data         = rs2_data_q;
  assign ex_imm              = imm_q;
  assign ex_rs1              = rs1_q;
  assign ex_rs2              = rs2_q;
  assign ex_rd               = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Only hazard-driven bubbles are lost cycles; empty ID slots are not counted.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush_ex || load_use) && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of ID slots with expected stall/capture, scoreboard of EX contents.
// Optional bubble counter is checked when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic              vld;
    ctrl_t             c;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   r1d;
    logic [XLEN-1:0]   r2d;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } out_t;

  typedef struct {
    logic        valid;
    logic        flush;
    ctrl_t       c;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        exp_stall;
    logic        exp_cap;
    int          exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic valid_id, flush_ex;
  ctrl_t c_in;
  logic [XLEN-1:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [REG_AW-1:0] rs1_id, rs2_id, rd_id;
  logic stall_if_id, ex_valid;
  logic ex_MemRead, ex_ALUSrc, ex_Jump, ex_SAJ, ex_Jump_Register;
  logic ex_Branch_equal, ex_Branch_not_equal, ex_Branch_greater, ex_Branch_less;
  logic [1:0] ex_MemWrite, ex_MemToReg;
  logic [2:0] ex_RegWrite;
  logic [3:0] ex_ALUOp1, ex_ALUOp2;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  out_t dut_out;
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .valid_id(valid_id),
    .MemRead(c_in.MemRead), .ALUSrc(c_in.ALUSrc), .Jump(c_in.Jump), .SAJ(c_in.SAJ),
    .Jump_Register(c_in.Jump_Register), .Branch_equal(c_in.Branch_equal),
    .Branch_not_equal(c_in.Branch_not_equal), .Branch_greater(c_in.Branch_greater),
    .Branch_less(c_in.Branch_less), .MemWrite(c_in.MemWrite), .MemToReg(c_in.MemToReg),
    .RegWrite(c_in.RegWrite), .ALUOp1(c_in.ALUOp1), .ALUOp2(c_in.ALUOp2),
    .pc_id(pc_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .flush_ex(flush_ex),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid),
    .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc), .ex_Jump(ex_Jump), .ex_SAJ(ex_SAJ),
    .ex_Jump_Register(ex_Jump_Register), .ex_Branch_equal(ex_Branch_equal),
    .ex_Branch_not_equal(ex_Branch_not_equal), .ex_Branch_greater(ex_Branch_greater),
    .ex_Branch_less(ex_Branch_less), .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
    .ex_RegWrite(ex_RegWrite), .ex_ALUOp1(ex_ALUOp1), .ex_ALUOp2(ex_ALUOp2),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  assign dut_out = {ex_valid, ex_MemRead, ex_ALUSrc, ex_Jump, ex_SAJ, ex_Jump_Register,
                    ex_Branch_equal, ex_Branch_not_equal, ex_Branch_greater, ex_Branch_less,
                    ex_MemWrite, ex_MemToReg, ex_RegWrite, ex_ALUOp1, ex_ALUOp2,
                    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic fl, input logic [XLEN-1:0] pc);
    valid_id    = v;
    c_in        = c;
    rs1_id      = r1;
    rs2_id      = r2;
    rd_id       = rd;
    flush_ex    = fl;
    pc_id       = pc;
    rs1_data_id = $urandom;
    rs2_data_id = $urandom;
    imm_id      = $urandom;
  endtask

  function automatic out_t expect_of(input logic cap);
    out_t e;
    e = '0;
    if (cap) e = '{vld: 1'b1, c: c_in, pc: pc_id, r1d: rs1_data_id, r2d: rs2_data_id,
                   imm: imm_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id};
    return e;
  endfunction

  task automatic pop_compare(input string name);
    out_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", name, dut_out);
    end else begin
      e = exp_q.pop_front();
      if (dut_out !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, dut_out, e);
      end
    end
  endtask

  ctrl_t c_add, c_lw, c_all, c_br;
  vec_t  tbl[15];

  initial begin
    c_add = '0; c_add.RegWrite = 3'b001; c_add.MemToReg = 2'b01; c_add.ALUOp2 = 4'h2;
    c_lw  = '0; c_lw.MemRead = 1'b1; c_lw.ALUSrc = 1'b1; c_lw.RegWrite = 3'b010;
    c_lw.MemToReg = 2'b10; c_lw.ALUOp1 = 4'h1;
    c_all = '1;
    c_br  = '0; c_br.Branch_not_equal = 1'b1; c_br.Branch_less = 1'b1; c_br.ALUOp1 = 4'h9;
    c_br.MemWrite = 2'b11;

    //            valid flush ctrl   rs1   rs2    rd    stall cap  cnt
    tbl[0]  = '{1'b1, 1'b0, c_add, 5'd1,  5'd2,  5'd5,  1'b0, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, c_lw,  5'd4,  5'd6,  5'd3,  1'b0, 1'b1, 0};
    tbl[2]  = '{1'b1, 1'b0, c_add, 5'd3,  5'd0,  5'd10, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b1, 1'b0, c_add, 5'd3,  5'd0,  5'd10, 1'b0, 1'b1, 1};
    tbl[4]  = '{1'b1, 1'b0, c_lw,  5'd5,  5'd6,  5'd0,  1'b0, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b0, c_all, 5'd7,  5'd0,  5'd8,  1'b0, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b0, c_lw,  5'd1,  5'd2,  5'd9,  1'b0, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b1, c_add, 5'd4,  5'd9,  5'd14, 1'b0, 1'b0, 2};
    tbl[8]  = '{1'b0, 1'b0, c_all, 5'd9,  5'd1,  5'd11, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b1, 1'b0, c_lw,  5'd1,  5'd2,  5'd9,  1'b0, 1'b1, 2};
    tbl[10] = '{1'b0, 1'b0, c_all, 5'd9,  5'd9,  5'd15, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b1, 1'b0, c_lw,  5'd1,  5'd2,  5'd12, 1'b0, 1'b1, 2};
    tbl[12] = '{1'b1, 1'b0, c_add, 5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 3};
    tbl[13] = '{1'b1, 1'b0, c_br,  5'd1,  5'd12, 5'd0,  1'b0, 1'b1, 3};
    tbl[14] = '{1'b1, 1'b1, c_add, 5'd1,  5'd2,  5'd16, 1'b0, 1'b0, 4};

    reset = 1'b1;
    drive(1'b1, c_all, 5'd0, 5'd0, 5'd31, 1'b0, 32'hDEAD_BEEF);
    #2;
    check("reset_out", 256'(dut_out), 256'(0));
    check("reset_stall", 256'(stall_if_id), 256'(0));
`ifdef ID_EX_BUBBLE_CNT_EN
    check("reset_cnt", 256'(bubble_cnt), 256'(0));
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].valid, tbl[i].c, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].flush,
            32'h0000_1000 + 32'(i * 4));
      #1;
      check($sformatf("row%0d_stall", i), 256'(stall_if_id), 256'(tbl[i].exp_stall));
      exp_q.push_back(expect_of(tbl[i].exp_cap));
      @(posedge clk);
      #1;
      pop_compare($sformatf("row%0d_ex", i));
`ifdef ID_EX_BUBBLE_CNT_EN
      check($sformatf("row%0d_cnt", i), 256'(bubble_cnt), 256'(tbl[i].exp_cnt));
`endif
    end

    // Load lands in EX, dependent waits in ID, then reset hits between edges.
    @(negedge clk);
    drive(1'b1, c_lw, 5'd1, 5'd2, 5'd20, 1'b0, 32'h0000_2000);
    exp_q.push_back(expect_of(1'b1));
    @(posedge clk);
    #1;
    pop_compare("rst_seq_load");
    @(negedge clk);
    drive(1'b1, c_add, 5'd20, 5'd3, 5'd21, 1'b0, 32'h0000_2004);
    #1;
    check("rst_seq_stall_before", 256'(stall_if_id), 256'(1));
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_out", 256'(dut_out), 256'(0));
    check("rst_async_stall", 256'(stall_if_id), 256'(0));
`ifdef ID_EX_BUBBLE_CNT_EN
    check("rst_async_cnt", 256'(bubble_cnt), 256'(0));
`endif
    @(posedge clk);
    #1;
    check("rst_held_out", 256'(dut_out), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_stall", 256'(stall_if_id), 256'(0));
    exp_q.push_back(expect_of(1'b1));
    @(posedge clk);
    #1;
    pop_compare("rst_release_capture");
`ifdef ID_EX_BUBBLE_CNT_EN
    check("rst_release_cnt", 256'(bubble_cnt), 256'(0));
`endif

    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined core: registers the control bundle produced by the instruction decoder together with the ID operands, and forwards them to EX one cycle later. It detects load-use hazards and requests an IF/ID stall. It inserts bubbles on load-use hazards, on invalid ID slots, and on EX-resolved control-flow flushes.

## Interface
Parameters:
- XLEN, 32, data/PC width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_id  in  1  ID slot holds a real instruction
- MemRead, ALUSrc, Jump, SAJ, Jump_Register  in  1 each  decoder controls
- Branch_equal, Branch_not_equal, Branch_greater, Branch_less  in  1 each  decoder branch controls
- MemWrite  in  2  decoder store type
- MemToReg  in  2  decoder writeback select
- RegWrite  in  3  decoder load/writeback type
- ALUOp1, ALUOp2  in  4 each  decoder ALU ops
- pc_id, rs1_data_id, rs2_data_id, imm_id  in  XLEN each  ID operands
- rs1_id, rs2_id, rd_id  in  REG_AW each  ID register addresses
- flush_ex  in  1  EX resolved a taken branch/jump; squash ID
- stall_if_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_* (one per control, operand and address input above)  out  same widths  registered copies
- bubble_cnt  out  32  present only with ID_EX_BUBBLE_CNT_EN

## Operation
- load_use = ex_valid & ex_MemRead & (ex_rd != 0) & valid_id & ((ex_rd == rs1_id) | (ex_rd == rs2_id)).
- stall_if_id = load_use & ~flush_ex. This output is combinational.
- The next ID/EX content is chosen by priority:
  1. flush_ex: load a bubble.
  2. load_use: load a bubble.
  3. ~valid_id: load a bubble.
  4. Otherwise, capture all inputs and set ex_valid = 1.
- Bubble: ex_valid = 0, every control output = 0 (MemWrite = 00, RegWrite = 000, ALUOp1/ALUOp2 = 0000), every data and address output = 0.
- The decoder output is taken as-is. There is no decode or opcode checking in this block.
- flush_ex together with load_use: the flush wins. No stall is raised, because the ID instruction is dead.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on ex_* after edge N.
- A load-use hazard costs exactly one bubble. On the next cycle ex_MemRead = 0, so the stall clears automatically and the held instruction is captured.
- Reset, asynchronous: all ex_* = 0, ex_valid = 0, bubble_cnt = 0. stall_if_id is 0 during reset because ex_valid = 0.
- Reset deasserting mid-stall: the first capture follows the normal priority rules. No state is retained from before reset.
- rd = x0 never triggers a stall.

## Configuration
- ID_EX_BUBBLE_CNT_EN defined:
  - bubble_cnt port exists.
  - The counter increments on each edge where a bubble is loaded because of flush_ex or load_use. Bubbles from ~valid_id are not counted.
  - The counter saturates at 32'hFFFF_FFFF.
  - The counter is cleared only by reset.
- ID_EX_BUBBLE_CNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - XLEN, REG_AW.
  - Packed struct ctrl_t bundling every decoder control field above.
  - Constant CTRL_BUBBLE, which is ctrl_t all-zero.
- Sub-module load_use_detect is purely combinational. Inputs: ex_valid, ex_MemRead, ex_rd, valid_id, rs1_id, rs2_id, flush_ex. Outputs: load_use, stall_if_id.
- The register bank and the optional counter live in id_ex_stage.

## Test plan
- Normal capture: ADD controls (RegWrite = 001, MemToReg = 01, ALUOp1 = 0000), rd_id = 5, valid_id = 1 → next cycle ex_valid = 1 and ex_* equal the inputs; stall_if_id = 0.
- Load-use: cycle 0 capture LW (MemRead = 1, rd = 3); cycle 1 ID has rs1_id = 3 → stall_if_id = 1 in cycle 1, bubble in EX in cycle 2, dependent instruction in EX in cycle 3; bubble_cnt = 1.
- x0 load: LW with rd = 0 followed by rs2_id = 0 → no stall; back-to-back capture.
- Flush overrides hazard: load_use condition true and flush_ex = 1 in the same cycle → stall_if_id = 0, next cycle ex_valid = 0 with all controls 0; bubble_cnt increments by 1.
- Async reset mid-operation: reset asserted between edges while ex_valid = 1 → ex_valid and all ex_* go to 0 immediately; after release, first valid instruction is captured next edge.
- Invalid slot: valid_id = 0 with nonzero controls → bubble loaded; bubble_cnt unchanged.
